// File: rtl/dmem_wait_responder.sv
// Data-memory responder for the MEM stage: word accesses complete after LATENCY cycles.
// Optional one-entry last-access buffer for zero-wait read hits: DMEM_LAST_HIT_EN.
module dmem_wait_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              ack_o,
  output logic              err_o
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  LIMIT    = (ADDR_W + 1)'(4 * DEPTH_WORDS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          op_q;
  logic                ack_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  logic req;
  logic hit;
  logic bad_in;
  logic bad_q;

  function automatic logic is_bad(
    input logic [ADDR_W-1:0] a,
    input logic              rd,
    input logic              wr
  );
    return (a[1:0] != 2'b00) || ({1'b0, a} >= LIMIT) || (rd && wr);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  assign req    = MemRead_i | MemWrite_i;
  assign bad_in = is_bad(addr_i, MemRead_i, MemWrite_i);
  assign bad_q  = is_bad(addr_q, op_q[1], op_q[0]);

  // Pipeline freeze: pending request in IDLE, or still counting in BUSY.
  assign stall_o = (state == IDLE) ? (req && !hit) : (cnt != '0);
  assign ack_o   = ack_q | hit;
  assign err_o   = err_q;

  // Control FSM: latch request, count down, raise ack/err for the final cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && !hit) begin
            state  <= BUSY;
            cnt    <= CNT_INIT;
            addr_q <= addr_i;
            data_q <= data_i;
            op_q   <= {MemRead_i, MemWrite_i};
            if (LATENCY == 1) begin
              ack_q <= 1'b1;
              err_q <= bad_in;
              if (MemRead_i)
                rdata_q <= bad_in ? '0 : mem[idx(addr_i)];
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              ack_q <= 1'b1;
              err_q <= bad_q;
              if (op_q[1])
                rdata_q <= bad_q ? '0 : mem[idx(addr_q)];
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage commit at the end of a legal write's ack cycle; reset drops it.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && state == BUSY && cnt == '0 && op_q[0] && !err_q)
      mem[idx(addr_q)] <= data_q;
  end

`ifdef DMEM_LAST_HIT_EN
  logic              buf_valid;
  logic [ADDR_W-3:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  assign hit = (state == IDLE) && buf_valid && MemRead_i && !MemWrite_i &&
               (addr_i[1:0] == 2'b00) && (addr_i[ADDR_W-1:2] == buf_addr);
  assign data_o = hit ? buf_data : rdata_q;

  // Remember the word of the last legal access for zero-wait reads.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      buf_valid <= 1'b0;
    end else if (state == BUSY && cnt == '0 && !err_q) begin
      buf_valid <= 1'b1;
      buf_addr  <= addr_q[ADDR_W-1:2];
      buf_data  <= op_q[0] ? data_q : rdata_q;
    end
  end
`else
  assign hit    = 1'b0;
  assign data_o = rdata_q;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder (LATENCY=4, DEPTH_WORDS=256).
// Table of single accesses plus reset, input-ignore, back-to-back and hit sequences.
module tb_dmem_wait_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        ack;
  logic        err;

  int errors = 0;
  int checks = 0;

  dmem_wait_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdata),
    .data_o(rdata), .stall_o(stall),
    .ack_o(ack), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the ack edge with inputs idle.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic e, input logic c,
                        input logic [31:0] x, input string nm);
    int cyc = 0;
    int bad_stall = 0;
    logic got = 1'b0;
    rd = r; wr = w; addr = a; wdata = d;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        check({nm, " latency"}, cyc, LAT);
        check({nm, " stall@ack"}, {31'b0, stall}, 0);
        check({nm, " err"}, {31'b0, err}, {31'b0, e});
        if (c) check({nm, " data"}, rdata, x);
      end else if (!stall) begin
        bad_stall++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!got) check({nm, " ack timeout"}, 0, 1);
    check({nm, " stall before ack"}, bad_stall, 0);
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int t_ack [2];
    int n_ack;
    tbl[0]  = '{1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h020, 32'h11112222, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h012, 32'h0,        1'b1, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h020, 32'h5,        1'b1, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h020, 32'h0,        1'b0, 1'b1, 32'h11112222};
    tbl[7]  = '{1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 1'b0, 1'b1, 32'h11112222};
    tbl[8]  = '{1'b1, 1'b0, 32'h010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[9]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
    tbl[10] = '{1'b0, 1'b1, 32'h011, 32'h99,       1'b1, 1'b1, 32'hA5A5A5A5};
    tbl[11] = '{1'b0, 1'b1, 32'h400, 32'h77,       1'b1, 1'b1, 32'hA5A5A5A5};
    tbl[12] = '{1'b0, 1'b1, 32'h014, 32'h0BADF00D, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 32'h010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[14] = '{1'b1, 1'b0, 32'h014, 32'h0,        1'b0, 1'b1, 32'h0BADF00D};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset data", rdata, 0);
    check("reset ack", {31'b0, ack}, 0);
    check("reset err", {31'b0, err}, 0);
    check("reset stall", {31'b0, stall}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
             tbl[i].err, tbl[i].chk, tbl[i].exp, $sformatf("vec%0d", i));

    // reset during a write abandons it
    rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset stall", {31'b0, stall}, 0);
    check("post-reset ack", {31'b0, ack}, 0);
    check("post-reset data", rdata, 0);
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    check("post-reset stray ack", n_ack, 0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h11112222, "rd after reset");

    // inputs are ignored while busy
    rd = 1'b1; addr = 32'h10;
    @(posedge clk); #1;
    rd = 1'b0; addr = 32'h14;
    n_ack = 0;
    for (int c = 1; c < 10 && n_ack == 0; c++) begin
      @(negedge clk);
      if (ack) begin
        n_ack++;
        check("ignore latency", c, LAT);
        check("ignore data", rdata, 32'hDEADBEEF);
      end
      @(posedge clk); #1;
    end
    check("ignore ack seen", n_ack, 1);

    // back-to-back reads, CPU advances only when stall is low
    rd = 1'b1; addr = 32'h10;
    n_ack = 0;
    for (int c = 0; c < 30 && n_ack < 2; c++) begin
      @(negedge clk);
      if (ack) begin
        t_ack[n_ack] = c;
        check($sformatf("b2b data%0d", n_ack), rdata,
              (n_ack == 0) ? 32'hDEADBEEF : 32'h0BADF00D);
        n_ack++;
        @(posedge clk); #1;
        addr = 32'h14;
      end else begin
        @(posedge clk); #1;
      end
    end
    rd = 1'b0;
    check("b2b ack count", n_ack, 2);
    if (n_ack == 2) begin
      check("b2b first ack", t_ack[0], LAT);
      check("b2b spacing", t_ack[1] - t_ack[0], LAT + 1);
    end

    // last-access buffer
    access(1'b0, 1'b1, 32'h40, 32'hCAFE, 1'b0, 1'b0, 32'h0, "wr 0x40");
`ifdef DMEM_LAST_HIT_EN
    rd = 1'b1; addr = 32'h40;
    @(negedge clk);
    check("hit stall", {31'b0, stall}, 0);
    check("hit ack", {31'b0, ack}, 1);
    check("hit err", {31'b0, err}, 0);
    check("hit data", rdata, 32'hCAFE);
    @(posedge clk); #1;
    rd = 1'b0;
`else
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'hCAFE, "rd 0x40");
`endif
    access(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, "rd 0x44");

    @(negedge clk);
    check("final idle stall", {31'b0, stall}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
